// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - camera pixel stream to 256x256 frame-buffer writer (option: CAM_GRAYSCALE_EN)
module cam_frame_writer #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int X_OFF    = 0,
    parameter int Y_OFF    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        freeze,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        frame_err
);

    typedef enum logic [1:0] {SYNC, ARMED, CAPTURE, HOLD} state_t;

    localparam logic [15:0] X_LAST = 16'(H_PIXELS - 1);
    localparam logic [15:0] Y_END  = 16'(V_LINES);
    localparam logic [15:0] X_LO   = 16'(X_OFF);
    localparam logic [15:0] Y_LO   = 16'(Y_OFF);
    localparam logic [16:0] X_HI   = 17'(X_OFF + 256);
    localparam logic [16:0] Y_HI   = 17'(Y_OFF + 256);

    state_t      state_q, state_d;
    logic        vs_q;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        frame_err_q, frame_err_d;

    logic rise, fall, pix_take, in_win;

`ifdef CAM_GRAYSCALE_EN
    // Luma from 8-bit-expanded channels, then packed back as equal R/G/B.
    function automatic logic [15:0] pix_conv(input logic [15:0] p);
        logic [7:0]  r8, g8, b8;
        logic [15:0] sum;
        logic [4:0]  g5;
        logic [5:0]  g6;
        r8  = {p[15:11], p[15:13]};
        g8  = {p[10:5], p[10:9]};
        b8  = {p[4:0], p[4:2]};
        sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
        g5  = 5'(sum >> 11);
        g6  = 6'(sum >> 10);
        return {g5, g6, g5};
    endfunction
`else
    function automatic logic [15:0] pix_conv(input logic [15:0] p);
        return p;
    endfunction
`endif

    assign rise     = vsync & ~vs_q;
    assign fall     = ~vsync & vs_q;
    assign pix_take = pix_valid & ~vsync & ~fall & ((state_q == CAPTURE) || (state_q == HOLD));
    assign in_win   = (x_q >= X_LO) && ({1'b0, x_q} < X_HI) &&
                      (y_q >= Y_LO) && ({1'b0, y_q} < Y_HI);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            SYNC:    if (rise) state_d = ARMED;
            ARMED:   if (fall) state_d = freeze ? HOLD : CAPTURE;
            CAPTURE: if (rise) begin
                state_d       = ARMED;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
                if (y_q != Y_END || x_q != 16'd0) frame_err_d = 1'b1;
            end
            HOLD:    if (rise) state_d = ARMED;
            default: state_d = SYNC;
        endcase

        // y parks at V_LINES; anything arriving after that is surplus and dropped.
        if (fall) begin
            x_d = 16'd0;
            y_d = 16'd0;
        end else if (pix_take) begin
            if (y_q == Y_END) begin
                frame_err_d = 1'b1;
            end else begin
                if (state_q == CAPTURE && in_win) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {8'(y_q - Y_LO), 8'(x_q - X_LO)};
                    wr_data_d = pix_conv(pix_data);
                end
                if (x_q == X_LAST) begin
                    x_d = 16'd0;
                    y_d = y_q + 16'd1;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SYNC;
            vs_q          <= 1'b1;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 16'd0;
            wr_data_q     <= 16'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vsync;
            x_q           <= x_d;
            y_q           <= y_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - scoreboard bench for cam_frame_writer
module tb_cam_frame_writer;
    localparam int H  = 10;
    localparam int V  = 8;
    localparam int XO = 3;
    localparam int YO = 2;

    logic        clk = 1'b0;
    logic        rst_n, vsync, freeze, pix_valid;
    logic [15:0] pix_data;
    logic        wr_en, frame_done, frame_err;
    logic [15:0] wr_addr, wr_data;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    cam_frame_writer #(.H_PIXELS(H), .V_LINES(V), .X_OFF(XO), .Y_OFF(YO)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .freeze(freeze),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_count(frame_count), .frame_err(frame_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wr_q[$];
    logic [7:0]  done_q[$];
    logic [15:0] last_addr = 16'd0;
    logic [15:0] last_data = 16'd0;

    // Reference model state: armed after a rise, active/cap decided at a fall.
    bit armed  = 1'b0;
    bit active = 1'b0;
    bit cap    = 1'b0;
    int m_count = 0;
    bit m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pix(input logic [15:0] p);
`ifdef CAM_GRAYSCALE_EN
        int r, g, b, gray;
        r = int'(p[15:11]) * 8 + int'(p[15:11]) / 4;
        g = int'(p[10:5]) * 4 + int'(p[10:5]) / 16;
        b = int'(p[4:0]) * 8 + int'(p[4:0]) / 4;
        gray = (77 * r + 150 * g + 29 * b) / 256;
        return 16'((gray / 8) * 2048 + (gray / 4) * 32 + gray / 8);
`else
        return p;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
                end else begin
                    logic [31:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", {16'd0, wr_addr}, {16'd0, e[31:16]});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
                    last_addr = e[31:16];
                    last_data = e[15:0];
                end
            end else begin
                chk("hold_addr", {16'd0, wr_addr}, {16'd0, last_addr});
                chk("hold_data", {16'd0, wr_data}, {16'd0, last_data});
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame_done: got count %0d expected no pulse", frame_count);
                end else begin
                    chk("done_count", {24'd0, frame_count}, {24'd0, done_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input int n, input int gap);
        logic [15:0] d;
        int x, y;
        repeat ($urandom_range(0, gap)) tick();
        d = 16'($urandom);
        pix_valid = 1'b1;
        pix_data  = d;
        x = n % H;
        y = n / H;
        if (active && n >= H * V) m_err = 1'b1;
        if (active && cap && n < H * V && x >= XO && x < XO + 256 && y >= YO && y < YO + 256)
            wr_q.push_back({8'((y - YO) % 256), 8'((x - XO) % 256), model_pix(d)});
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic model_fall();
        active = armed;
        cap    = !freeze;
        armed  = 1'b0;
    endtask

    task automatic model_rise(input int npix);
        if (active && cap) begin
            m_count = (m_count + 1) % 256;
            done_q.push_back(8'(m_count));
            if (npix != H * V) m_err = 1'b1;
        end
        active = 1'b0;
        armed  = 1'b1;
    endtask

    task automatic send_frame(input int npix, input int frz_mid, input int gap);
        for (int k = 0; k < 2; k++) begin
            pix_valid = 1'b1;
            pix_data  = 16'($urandom);
            tick();
            pix_valid = 1'b0;
            tick();
        end
        vsync     = 1'b0;
        pix_valid = 1'($urandom_range(0, 1));
        pix_data  = 16'($urandom);
        model_fall();
        tick();
        pix_valid = 1'b0;
        tick();
        for (int n = 0; n < npix; n++) begin
            if (n == npix / 2 && frz_mid >= 0) freeze = 1'(frz_mid);
            push_pixel(n, gap);
        end
        tick();
        vsync = 1'b1;
        model_rise(npix);
        repeat (3) tick();
        chk("frame_count", {24'd0, frame_count}, 32'(m_count));
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    endtask

    task automatic model_reset();
        armed = 1'b0; active = 1'b0; cap = 1'b0;
        m_count = 0; m_err = 1'b0;
        last_addr = 16'd0; last_data = 16'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {16'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_frame_count"}, {24'd0, frame_count}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic reset_mid_frame();
        vsync = 1'b0;
        model_fall();
        tick();
        tick();
        for (int n = 0; n < 15; n++) push_pixel(n, 1);
        repeat (2) tick();
        chk("pending_before_reset", 32'(wr_q.size()), 32'd0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 15; n < H * V; n++) push_pixel(n, 1);
        tick();
        vsync = 1'b1;
        model_rise(H * V);
        repeat (3) tick();
        chk("post_rst_count", {24'd0, frame_count}, 32'(m_count));
        chk("post_rst_err", {31'd0, frame_err}, {31'd0, m_err});
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b1; freeze = 1'b0; pix_valid = 1'b0; pix_data = 16'd0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        send_frame(H * V, -1, 1);
        send_frame(H * V, -1, 1);
        send_frame(H * V, 1, 1);
        send_frame(H * V, 0, 1);
        send_frame(H * V, -1, 1);
        send_frame(3 * H + 4, -1, 1);
        send_frame(H * V, -1, 1);
        send_frame(H * V + 5, -1, 1);
        send_frame(0, -1, 1);

        reset_mid_frame();
        for (int i = 0; i < 255; i++) send_frame(H * V, -1, 0);
        chk("count_255", {24'd0, frame_count}, 32'd255);
        send_frame(H * V, -1, 0);
        chk("count_wrap", {24'd0, frame_count}, 32'd0);
        chk("err_clean", {31'd0, frame_err}, 32'd0);

        repeat (3) tick();
        chk("writes_left", 32'(wr_q.size()), 32'd0);
        chk("dones_left", 32'(done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
